// File: rtl/alu_ctrl.sv
// Frame sequencer for the ALU. It collects operand A, operand B and an opcode, presents them to the ALU, and returns the result.
// Optional feature: define ALU_CTRL_OPCHECK_EN to reject unsupported opcodes with an error pulse.
module alu_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int MODE_WIDTH     = 6,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  output logic [MODE_WIDTH-1:0] o_alu_mode,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_err,
  output logic                  o_busy
);

  typedef enum logic [2:0] {GET_A, GET_B, GET_OP, EXEC, SEND} state_t;

  // The counter only has to reach TIMEOUT_CYCLES-1, because expiry is taken on the following edge.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state, next_state;
  logic [CW-1:0] count;
  logic          rx_fire;
  logic          waiting;
  logic          timeout_fire;
  logic          op_bad;

  assign rx_fire      = i_rx_valid & o_rx_ready;
  assign waiting      = (state == GET_B) || (state == GET_OP);
  // A word handshake on the expiry edge takes priority over the timeout.
  assign timeout_fire = (TIMEOUT_CYCLES > 0) && waiting && !rx_fire && (count == TO_LAST);

`ifdef ALU_CTRL_OPCHECK_EN
  function automatic logic op_supported(input logic [MODE_WIDTH-1:0] op);
    return op inside {MODE_WIDTH'(8'h20), MODE_WIDTH'(8'h22), MODE_WIDTH'(8'h24),
                      MODE_WIDTH'(8'h25), MODE_WIDTH'(8'h26), MODE_WIDTH'(8'h27),
                      MODE_WIDTH'(8'h03), MODE_WIDTH'(8'h02)};
  endfunction
  assign op_bad = !op_supported(i_rx_data[MODE_WIDTH-1:0]);
`else
  assign op_bad = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= GET_A;
    else         state <= next_state;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
    next_state = state;
    unique case (state)
      GET_A:  if (rx_fire) next_state = GET_B;
      GET_B: begin
        if (rx_fire)           next_state = GET_OP;
        else if (timeout_fire) next_state = GET_A;
      end
      GET_OP: begin
        if (rx_fire)           next_state = op_bad ? GET_A : EXEC;
        else if (timeout_fire) next_state = GET_A;
      end
      EXEC:   next_state = SEND;
      SEND:   if (i_tx_ready) next_state = GET_A;
      default: next_state = GET_A;
    endcase
  end

  always_comb begin
    o_rx_ready = (state == GET_A) || waiting;
    o_busy     = (state != GET_A);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_mode <= '0;
      o_tx_data  <= '0;
      o_tx_valid <= 1'b0;
      o_err      <= 1'b0;
      count      <= '0;
    end else begin
      o_err <= timeout_fire || ((state == GET_OP) && rx_fire && op_bad);

      if (waiting && !rx_fire && !timeout_fire) count <= count + 1'b1;
      else                                      count <= '0;

      if (rx_fire) begin
        case (state)
          GET_A:   o_alu_a    <= i_rx_data;
          GET_B:   o_alu_b    <= i_rx_data;
          GET_OP:  o_alu_mode <= i_rx_data[MODE_WIDTH-1:0];
          default: ;
        endcase
      end

      if (state == EXEC) begin
        o_tx_data  <= i_alu_result;
        o_tx_valid <= 1'b1;
      end else if ((state == SEND) && i_tx_ready) begin
        o_tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Randomised self-checking bench for alu_ctrl; a behavioural ALU stub drives i_alu_result.
module tb_alu_ctrl;
  localparam int DW = 8;
  localparam int MW = 6;
  localparam int TO = 10;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic [DW-1:0] i_rx_data;
  logic          i_rx_valid;
  logic          o_rx_ready;
  logic [DW-1:0] o_alu_a, o_alu_b;
  logic [MW-1:0] o_alu_mode;
  logic [DW-1:0] i_alu_result;
  logic [DW-1:0] o_tx_data;
  logic          o_tx_valid;
  logic          i_tx_ready;
  logic          o_err;
  logic          o_busy;

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return {a[7], a[7:1]};
      6'h02:   return a >> 1;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit ref_rejects(input logic [5:0] op);
`ifdef ALU_CTRL_OPCHECK_EN
    return !(op inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02});
`else
    return 1'b0;
`endif
  endfunction

  assign i_alu_result = ref_alu(o_alu_a, o_alu_b, o_alu_mode);

  alu_ctrl #(.DATA_WIDTH(DW), .MODE_WIDTH(MW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_mode(o_alu_mode),
    .i_alu_result(i_alu_result),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_err(o_err), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input string name);
    n_total++; if (o_rx_ready !== 1'b1) $display("FAIL %s rx_ready: got %b want 1", name, o_rx_ready); else n_pass++;
    i_rx_data  = w;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
    i_rx_data  = 8'($urandom);
  endtask

  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      tick();
      n_total++; if (o_err !== 1'b0) $display("FAIL %s idle err: got %b want 0", name, o_err); else n_pass++;
      n_total++; if (o_busy !== 1'b1) $display("FAIL %s idle busy: got %b want 1", name, o_busy); else n_pass++;
    end
  endtask

  task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          input int gap_b, input int gap_op, input int hold, input string name);
    logic [7:0] exp;
    bit         rej;
    exp = ref_alu(a, b, op[5:0]);
    rej = ref_rejects(op[5:0]);
    i_tx_ready = (hold == 0);
    send_word(a, name);
    idle(gap_b, name);
    send_word(b, name);
    idle(gap_op, name);
    send_word(op, name);
    n_total++; if (o_alu_a !== a) $display("FAIL %s alu_a: got %h want %h", name, o_alu_a, a); else n_pass++;
    n_total++; if (o_alu_b !== b) $display("FAIL %s alu_b: got %h want %h", name, o_alu_b, b); else n_pass++;
    n_total++; if (o_alu_mode !== op[5:0]) $display("FAIL %s alu_mode: got %h want %h", name, o_alu_mode, op[5:0]); else n_pass++;
    n_total++; if (o_err !== rej) $display("FAIL %s err after op: got %b want %b", name, o_err, rej); else n_pass++;
    n_total++; if (o_tx_valid !== 1'b0) $display("FAIL %s tx_valid in exec: got %b want 0", name, o_tx_valid); else n_pass++;
    if (rej) begin
      n_total++; if (o_rx_ready !== 1'b1) $display("FAIL %s rx_ready after reject: got %b want 1", name, o_rx_ready); else n_pass++;
      tick();
      n_total++; if (o_err !== 1'b0) $display("FAIL %s err width: got %b want 0", name, o_err); else n_pass++;
      n_total++; if (o_tx_valid !== 1'b0) $display("FAIL %s tx_valid after reject: got %b want 0", name, o_tx_valid); else n_pass++;
      return;
    end
    n_total++; if (o_rx_ready !== 1'b0) $display("FAIL %s rx_ready in exec: got %b want 0", name, o_rx_ready); else n_pass++;
    tick();
    n_total++; if (o_tx_valid !== 1'b1) $display("FAIL %s tx_valid: got %b want 1", name, o_tx_valid); else n_pass++;
    n_total++; if (o_tx_data !== exp) $display("FAIL %s tx_data: got %h want %h", name, o_tx_data, exp); else n_pass++;
    n_total++; if (o_err !== 1'b0) $display("FAIL %s err in send: got %b want 0", name, o_err); else n_pass++;
    for (int i = 0; i < hold; i++) begin
      tick();
      n_total++; if (o_tx_valid !== 1'b1 || o_tx_data !== exp)
        $display("FAIL %s hold %0d: got valid %b data %h want 1 %h", name, i, o_tx_valid, o_tx_data, exp); else n_pass++;
      n_total++; if (o_rx_ready !== 1'b0) $display("FAIL %s rx_ready in hold: got %b want 0", name, o_rx_ready); else n_pass++;
    end
    i_tx_ready = 1'b1;
    tick();
    n_total++; if (o_tx_valid !== 1'b0) $display("FAIL %s tx_valid after handshake: got %b want 0", name, o_tx_valid); else n_pass++;
    n_total++; if (o_rx_ready !== 1'b1) $display("FAIL %s rx_ready after handshake: got %b want 1", name, o_rx_ready); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL %s busy after handshake: got %b want 0", name, o_busy); else n_pass++;
    i_tx_ready = 1'($urandom);
  endtask

  task automatic check_reset_values(input string name);
    n_total++; if (o_alu_a !== 8'h00 || o_alu_b !== 8'h00 || o_alu_mode !== 6'h00)
      $display("FAIL %s alu regs: got %h %h %h want 00 00 00", name, o_alu_a, o_alu_b, o_alu_mode); else n_pass++;
    n_total++; if (o_tx_data !== 8'h00 || o_tx_valid !== 1'b0)
      $display("FAIL %s tx: got data %h valid %b want 00 0", name, o_tx_data, o_tx_valid); else n_pass++;
    n_total++; if (o_err !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL %s err/busy: got %b %b want 0 0", name, o_err, o_busy); else n_pass++;
    n_total++; if (o_rx_ready !== 1'b1) $display("FAIL %s rx_ready: got %b want 1", name, o_rx_ready); else n_pass++;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_rx_valid = 1'b0; i_rx_data = 8'hA5; i_tx_ready = 1'b0;
    tick(); tick();
    check_reset_values("reset");
    i_reset = 1'b0;
    tick();
    check_reset_values("post_reset");
  endtask

  task automatic test_directed();
    do_frame(8'h05, 8'h03, 8'h20, 0, 0, 0, "add");
    do_frame(8'h03, 8'h05, 8'h22, 0, 0, 0, "sub");
    do_frame(8'h80, 8'h00, 8'h03, 0, 0, 0, "sra");
    do_frame(8'h80, 8'h00, 8'h02, 0, 0, 0, "srl");
  endtask

  task automatic test_backpressure();
    do_frame(8'hF0, 8'h0F, 8'h25, 0, 0, 6, "backpressure");
  endtask

  task automatic test_timeout();
    for (int stage = 1; stage <= 2; stage++) begin
      send_word(8'h11, "timeout");
      if (stage == 2) send_word(8'h22, "timeout");
      for (int i = 1; i <= TO; i++) begin
        tick();
        n_total++; if (o_err !== (i == TO)) $display("FAIL timeout%0d err at %0d: got %b want %b", stage, i, o_err, (i == TO)); else n_pass++;
      end
      n_total++; if (o_busy !== 1'b0 || o_rx_ready !== 1'b1)
        $display("FAIL timeout%0d state: got busy %b ready %b want 0 1", stage, o_busy, o_rx_ready); else n_pass++;
      n_total++; if (o_alu_a !== 8'h11) $display("FAIL timeout%0d alu_a kept: got %h want 11", stage, o_alu_a); else n_pass++;
      tick();
      n_total++; if (o_err !== 1'b0) $display("FAIL timeout%0d err width: got %b want 0", stage, o_err); else n_pass++;
    end
    do_frame(8'h01, 8'h01, 8'h20, 0, 0, 0, "after_timeout");
    do_frame(8'h44, 8'h55, 8'h26, TO - 1, TO - 1, 1, "timeout_race");
  endtask

  task automatic test_bad_opcode();
    do_frame(8'h12, 8'h34, 8'h3F, 0, 0, 0, "bad_opcode");
  endtask

  task automatic test_random();
    logic [7:0] ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
    logic [7:0] op;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 4) == 0) op = 8'($urandom_range(0, 255));
      else                           op = ops[$urandom_range(0, 7)];
      do_frame(8'($urandom), 8'($urandom), op, $urandom_range(0, TO - 1),
               $urandom_range(0, TO - 1), $urandom_range(0, 3), $sformatf("random%0d", n));
    end
  endtask

  task automatic test_reset_in_send();
    i_tx_ready = 1'b0;
    send_word(8'h09, "reset_send");
    send_word(8'h07, "reset_send");
    send_word(8'h24, "reset_send");
    tick();
    n_total++; if (o_tx_valid !== 1'b1) $display("FAIL reset_send pre valid: got %b want 1", o_tx_valid); else n_pass++;
    #2 i_reset = 1'b1;
    #1 check_reset_values("reset_send_async");
    tick();
    check_reset_values("reset_send_held");
    i_reset = 1'b0;
    do_frame(8'h0C, 8'h0A, 8'h24, 0, 0, 0, "after_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_timeout();
    test_bad_opcode();
    test_random();
    test_reset_in_send();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Frame-level sequencer for the ALU datapath. It accepts a three-word request stream (operand A, operand B, opcode) over a valid/ready input channel and drives the ALU operand and mode inputs from registers. It captures the combinational result and returns it over a valid/ready output channel. It sits between the board-level byte interface and the ALU, so the ALU is only ever presented with stable, complete operand sets.

## Interface
- DATA_WIDTH, 8, operand/result/stream word width
- MODE_WIDTH, 6, ALU opcode width; taken from bits [MODE_WIDTH-1:0] of the third word
- TIMEOUT_CYCLES, 1000, max idle cycles between words of one frame; 0 disables timeout

Ports:
- i_clk  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_rx_data  in  DATA_WIDTH  request word
- i_rx_valid  in  1  request word valid
- o_rx_ready  out  1  block can accept a request word
- o_alu_a  out  DATA_WIDTH  registered operand A to ALU
- o_alu_b  out  DATA_WIDTH  registered operand B to ALU
- o_alu_mode  out  MODE_WIDTH  registered opcode to ALU
- i_alu_result  in  DATA_WIDTH  combinational ALU result
- o_tx_data  out  DATA_WIDTH  result word
- o_tx_valid  out  1  result word valid
- i_tx_ready  in  1  downstream accepts result
- o_err  out  1  one-cycle pulse: frame aborted
- o_busy  out  1  high in any state other than GET_A

## Operation
- States: GET_A, GET_B, GET_OP, EXEC, SEND. Reset state is GET_A.
- o_rx_ready = 1 in GET_A/GET_B/GET_OP, else 0. Decoded from the state register, so it reads 1 during reset.
- Transfer on an input edge where i_rx_valid & o_rx_ready are both high:
  - GET_A: load o_alu_a, go to GET_B.
  - GET_B: load o_alu_b, go to GET_OP.
  - GET_OP: load o_alu_mode, go to EXEC.
- EXEC lasts exactly one cycle, with the ALU inputs stable. At its closing edge: o_tx_data <= i_alu_result, o_tx_valid <= 1, go to SEND.
- SEND: hold o_tx_data and o_tx_valid until i_tx_ready. On that handshake edge: o_tx_valid <= 0, go to GET_A.
- o_alu_* hold their last loaded values between frames. They are not cleared on frame completion.
- Result is the ALU output truncated to DATA_WIDTH. The block does no arithmetic itself.
- Timeout (TIMEOUT_CYCLES>0):
  - Counter runs in GET_B and GET_OP, clears on every accepted word and in every other state.
  - When the counter reaches TIMEOUT_CYCLES: go to GET_A, pulse o_err, discard the partial frame. o_alu_* keep their partially loaded values.
  - GET_A never times out.
  - If a word handshake and timeout expiry fall on the same edge, the handshake wins and the counter clears.
- Reset mid-frame (any state): immediately returns to GET_A, clears o_tx_valid, o_err and the counter. No partial result is emitted.

## Timing
- Reset values: o_alu_a=0, o_alu_b=0, o_alu_mode=0, o_tx_data=0, o_tx_valid=0, o_err=0, o_busy=0, o_rx_ready=1.
- Opcode accepted at edge k gives EXEC during cycle k..k+1, and o_tx_valid=1 from edge k+1.
- Minimum frame: 3 accept edges, plus 1 EXEC edge, plus 1 SEND edge. At full throughput that is one result per 5 cycles.
- o_rx_ready is high in the cycle after the SEND handshake edge.
- i_tx_ready is ignored outside SEND. i_rx_valid is ignored outside the GET_* states.
- o_err is high for exactly one cycle per abort.

## Configuration
- ALU_CTRL_OPCHECK_EN defined:
  - At the GET_OP accept edge, the opcode is checked against {0x20,0x22,0x24,0x25,0x26,0x27,0x03,0x02}.
  - Unsupported opcode: o_alu_mode is still loaded, EXEC and SEND are skipped, o_err pulses one cycle, and the state returns to GET_A. No o_tx_valid.
- Undefined: every opcode proceeds through EXEC/SEND. Unsupported codes return whatever the ALU produces (0x00), and o_err is raised only by timeout.

## Test plan
- Words 0x05, 0x03, 0x20 with i_tx_ready=1 -> o_tx_valid high one cycle after the opcode edge, o_tx_data=0x08, o_rx_ready back high next cycle.
- Words 0x03, 0x05, 0x22 -> 0xFE. Then 0x80, 0x00, 0x03 -> 0xC0. Then 0x80, 0x00, 0x02 -> 0x40.
- Back-pressure: frame 0xF0, 0x0F, 0x25 with i_tx_ready=0 for 6 cycles -> o_tx_data=0xFF and o_tx_valid held steady, o_rx_ready=0 throughout. Release -> single transfer.
- Timeout (TIMEOUT_CYCLES=10): send 0x11 only, then idle -> o_err pulses exactly 10 cycles after the accept edge. The next frame 0x01, 0x01, 0x20 yields 0x02.
- Opcode 0x3F after 0x12, 0x34:
  - With ALU_CTRL_OPCHECK_EN: o_err pulse, no o_tx_valid.
  - Without: o_tx_data=0x00 with o_tx_valid.
- Assert i_reset asynchronously while in SEND (o_tx_valid=1) -> o_tx_valid drops immediately, all outputs at reset values, and the next full frame completes normally.
